// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, one quotient bit per clock
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (dividend, divisor; unsigned)
//   out_valid/out_ready result handshake (quotient, remainder, div_by_zero)
//   busy               high whenever the FSM is not idle
module seq_restoring_divider #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  busy
);
   localparam int CW = DIVIDEND_W > 1 ? $clog2(DIVIDEND_W) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_next;
   logic [DIVIDEND_W-1:0] q;
   logic [DIVISOR_W-1:0] d, r, diff;
   logic [DIVISOR_W:0] t;
   logic [CW-1:0] cnt;
   logic dbz, ge, accept;
   assign accept = state == IDLE && in_valid;
   assign t = {r, q[DIVIDEND_W-1]};
   assign ge = t >= {1'b0, d};
   // r < d always holds after a step, so the difference fits in DIVISOR_W bits
   // and the dropped carry bit of t is irrelevant modulo 2^DIVISOR_W
   assign diff = t[DIVISOR_W-1:0] - d;
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign busy = state != IDLE;
   assign quotient = q;
   assign remainder = r;
   assign div_by_zero = dbz;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      if (accept) state_next = divisor == '0 ? DONE : CALC;
      else if (state == CALC && cnt == '0) state_next = DONE;
      else if (state == DONE && out_ready) state_next = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q   <= '0;
         d   <= '0;
         r   <= '0;
         cnt <= '0;
         dbz <= 1'b0;
      end else if (accept) begin
         d   <= divisor;
         r   <= '0;
         cnt <= CW'(DIVIDEND_W - 1);
         dbz <= divisor == '0;
         q   <= divisor == '0 ? '1 : dividend;
      end else if (state == CALC) begin
         q <= {q[DIVIDEND_W-2:0], ge};
         r <= ge ? diff : t[DIVISOR_W-1:0];
         if (cnt != '0) cnt <= cnt - CW'(1);
      end
   end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and exhaustive checks of seq_restoring_divider
module tb_seq_restoring_divider;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic in_ready, out_valid, div_by_zero, busy;
   logic [7:0] quotient;
   logic [3:0] remainder;
   int errors = 0, checks = 0;
   seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // issue one op, measure latency, optionally stall with ignored in_valid pulses, then release
   task automatic do_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                        input int elat, input int stall);
      int lat;
      @(negedge clk);
      chk({tag, " in_ready"}, 32'(in_ready), 1);
      in_valid = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(remainder), 32'(er));
      chk({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
      for (int i = 0; i < stall; i++) begin
         in_valid = i[0]; dividend = 8'($urandom); divisor = 4'($urandom);
         @(negedge clk);
         chk({tag, " stall q"}, 32'(quotient), 32'(eq));
         chk({tag, " stall r"}, 32'(remainder), 32'(er));
         chk({tag, " stall ov"}, 32'(out_valid), 1);
         chk({tag, " stall ir"}, 32'(in_ready), 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " ov drop"}, 32'(out_valid), 0);
      chk({tag, " idle"}, 32'(busy), 0);
   endtask
   initial begin
      #12;
      chk("rst in_ready", 32'(in_ready), 1);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst quotient", 32'(quotient), 0);
      chk("rst remainder", 32'(remainder), 0);
      chk("rst dbz", 32'(div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      do_op("35/7", 8'd35, 4'd7, 8'd5, 4'd0, 1'b0, 8, 0);
      do_op("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, 0);
      do_op("100/3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 0);
      do_op("5/15", 8'd5, 4'd15, 8'd0, 4'd5, 1'b0, 8, 0);
      do_op("225/15", 8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 8, 0);
      do_op("42/0", 8'd42, 4'd0, 8'hFF, 4'd0, 1'b1, 0, 0);
      do_op("stall 100/3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 5);
      @(negedge clk);
      in_valid = 1'b1; dividend = 8'd123; divisor = 4'd5;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst out_valid", 32'(out_valid), 0);
      chk("midrst in_ready", 32'(in_ready), 1);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst quotient", 32'(quotient), 0);
      @(negedge clk);
      rst = 1'b0;
      do_op("200/9", 8'd200, 4'd9, 8'd22, 4'd2, 1'b0, 8, 0);
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            int eq, er;
            eq = b == 0 ? 255 : a / b;
            er = b == 0 ? 0 : a % b;
            do_op("sweep", 8'(a), 4'(b), 8'(eq), 4'(er), b == 0, b == 0 ? 0 : 8, int'($urandom_range(0, 2)));
            if (b != 0) chk("sweep invariant", 32'(int'(quotient) * b + int'(remainder) == a && remainder < b), 1);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
